// File: rtl/jtag_host_arbiter.sv
// jtag_host_arbiter
//   Shares one target JTAG connector between N_HOST FTDI MPSSE channels.
//   A host acquires the target by clocking it (TCK rise or TMS toggle).
//   Ownership passes round-robin among hosts with pending activity. It is
//   released after IDLE_CYCLES without owner activity or on a JP1 button
//   press, and is then followed by HOLDOFF_CYCLES of parked target outputs.
//
//   Optional build macro: BB_SRST_STRETCH_EN
//     defined   : any host's reset request pulls nSRST low, each assertion
//                 is stretched by SRST_STRETCH cycles, and the idle counter
//                 is frozen while nSRST is low.
//     undefined : only the owner's synchronised request pulls nSRST low.
//
// Ports
//   CLK, nRST           clock, asynchronous active-low reset
//   host_tck/tdi/tms    per-host JTAG drive (asynchronous to CLK)
//   host_ntrst          per-host nTRST
//   host_srst_req       per-host system reset request (active-high)
//   host_tdo            per-host TDO return (1 for non-owners)
//   TCK/TDI/TMS/nTRST   target JTAG outputs; TDO target data in
//   nSRST               open-drain target reset (0 or Z)
//   BUTTON              JP1 button, active-low; LED high while owned
//   grant               one-hot owner, 0 when unowned
module jtag_host_arbiter #(
  parameter int N_HOST          = 2,
  parameter int IDLE_CYCLES     = 1024,
  parameter int HOLDOFF_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 4096,
  parameter int SRST_STRETCH    = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [N_HOST-1:0] host_tck,
  input  logic [N_HOST-1:0] host_tdi,
  input  logic [N_HOST-1:0] host_tms,
  input  logic [N_HOST-1:0] host_ntrst,
  input  logic [N_HOST-1:0] host_srst_req,
  output logic [N_HOST-1:0] host_tdo,
  output logic              TCK,
  output logic              TDI,
  output logic              TMS,
  output logic              nTRST,
  input  logic              TDO,
  inout  wire               nSRST,
  input  logic              BUTTON,
  output logic              LED,
  output logic [N_HOST-1:0] grant
);

  localparam int PW = (N_HOST > 1) ? $clog2(N_HOST) : 1;

`ifdef BB_SRST_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_OWNED, S_HOLDOFF} state_t;

  state_t            r_state, w_state_nxt;
  logic [N_HOST-1:0] r_tck_p0, r_tck_p1, r_tck_p2;
  logic [N_HOST-1:0] r_tms_p0, r_tms_p1, r_tms_p2;
  logic [N_HOST-1:0] r_srst_p0, r_srst_p1;
  logic [N_HOST-1:0] r_act, r_pending, r_grant;
  logic              r_btn_p0, r_btn_p1, r_btn_db, r_press;
  logic [15:0]       r_db_cnt, r_idle;
  logic [7:0]        r_hold, r_stretch;
  logic [PW-1:0]     r_rr, w_sel, w_rr_nxt;
  logic [N_HOST-1:0] w_act, w_sel_oh, w_grant_set;
  logic              w_found, w_own_act, w_timeout, w_freeze;
  logic              w_srst_req, w_srst_low;

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous synchronised
  // value so edges and toggles can be detected.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_tck_p0  <= '0; r_tck_p1 <= '0; r_tck_p2 <= '0;
      r_tms_p0  <= '0; r_tms_p1 <= '0; r_tms_p2 <= '0;
      r_srst_p0 <= '0; r_srst_p1 <= '0;
      r_btn_p0  <= 1'b1; r_btn_p1 <= 1'b1;
      r_act     <= '0;
    end else begin
      r_tck_p0  <= host_tck;      r_tck_p1 <= r_tck_p0; r_tck_p2 <= r_tck_p1;
      r_tms_p0  <= host_tms;      r_tms_p1 <= r_tms_p0; r_tms_p2 <= r_tms_p1;
      r_srst_p0 <= host_srst_req; r_srst_p1 <= r_srst_p0;
      r_btn_p0  <= BUTTON;        r_btn_p1 <= r_btn_p0;
      r_act     <= w_act;
    end
  end

  assign w_act = (r_tck_p1 & ~r_tck_p2) | (r_tms_p1 ^ r_tms_p2);

  // A press is the debounced level falling; it lasts one cycle, so it only
  // has an effect if it lands while a host owns the target.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_btn_db <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_btn_p1 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
        r_btn_db <= r_btn_p1;
        r_db_cnt <= '0;
        r_press  <= ~r_btn_p1;
      end else begin
        r_db_cnt <= r_db_cnt + 16'd1;
      end
    end
  end

  // Round-robin pick: scanning offsets from high to low leaves the pending
  // host closest to r_rr as the final assignment.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = N_HOST - 1; i >= 0; i--) begin
      for (int k = 0; k < N_HOST; k++) begin
        if (r_pending[k] && (k == (int'(r_rr) + i) % N_HOST)) begin
          w_found = 1'b1;
          w_sel   = PW'(k);
        end
      end
    end
    w_sel_oh = '0;
    for (int k = 0; k < N_HOST; k++) w_sel_oh[k] = (int'(w_sel) == k);
    w_rr_nxt = (int'(w_sel) == N_HOST - 1) ? '0 : w_sel + 1'b1;
  end

  assign w_grant_set = (r_state == S_IDLE && w_found) ? w_sel_oh : '0;
  assign w_own_act   = |(r_act & r_grant);
  assign w_freeze    = STRETCH_EN & w_srst_low;
  assign w_timeout   = (r_idle == 16'(IDLE_CYCLES - 1)) && !w_freeze;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_state_nxt = S_OWNED;
      S_OWNED:   if (r_press || w_timeout) w_state_nxt = S_HOLDOFF;
      S_HOLDOFF: if (r_hold == 8'd0) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    LED = (r_state == S_OWNED);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_grant   <= '0;
      r_rr      <= '0;
      r_pending <= '0;
      r_idle    <= '0;
      r_hold    <= '0;
    end else begin
      r_pending <= (r_pending | (r_act & ~r_grant)) & ~w_grant_set;
      if (r_state == S_IDLE && w_found) begin
        r_grant <= w_sel_oh;
        r_rr    <= w_rr_nxt;
      end
      if (r_state == S_OWNED && w_state_nxt == S_HOLDOFF) begin
        r_grant <= '0;
        r_hold  <= 8'(HOLDOFF_CYCLES - 1);
      end else if (r_hold != 8'd0) begin
        r_hold  <= r_hold - 8'd1;
      end
      if (r_state != S_OWNED)  r_idle <= '0;
      else if (w_freeze)       r_idle <= r_idle;
      else if (w_own_act)      r_idle <= '0;
      else                     r_idle <= r_idle + 16'd1;
    end
  end

  // Reset stretch: reloaded while a request is active, counts down after.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)             r_stretch <= '0;
    else if (!STRETCH_EN)  r_stretch <= '0;
    else if (w_srst_req)   r_stretch <= 8'(SRST_STRETCH);
    else if (r_stretch != 8'd0) r_stretch <= r_stretch - 8'd1;
  end

  assign w_srst_req = STRETCH_EN ? (|r_srst_p1) : (|(r_srst_p1 & r_grant));
  assign w_srst_low = w_srst_req | (STRETCH_EN & (r_stretch != 8'd0));
  assign nSRST      = w_srst_low ? 1'b0 : 1'bz;

  // Target pins follow the owner directly; parked values when unowned.
  always_comb begin
    TCK      = 1'b0;
    TMS      = 1'b1;
    TDI      = 1'b0;
    nTRST    = 1'b1;
    host_tdo = '1;
    for (int k = 0; k < N_HOST; k++) begin
      if (r_grant[k]) begin
        TCK         = host_tck[k];
        TMS         = host_tms[k];
        TDI         = host_tdi[k];
        nTRST       = host_ntrst[k];
        host_tdo[k] = TDO;
      end
    end
  end

  assign grant = r_grant;

endmodule

// File: tb/tb_jtag_host_arbiter.sv
module tb_jtag_host_arbiter;
  logic       CLK = 1'b0;
  logic       nRST;
  logic [1:0] host_tck, host_tdi, host_tms, host_ntrst, host_srst_req;
  wire  [1:0] host_tdo;
  wire        TCK, TDI, TMS, nTRST, LED;
  logic       TDO, BUTTON;
  wire  [1:0] grant;
  wire        nSRST;

  pullup (nSRST);

  jtag_host_arbiter #(
    .N_HOST(2), .IDLE_CYCLES(1024), .HOLDOFF_CYCLES(4),
    .DEBOUNCE_CYCLES(4096), .SRST_STRETCH(255)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .host_tck(host_tck), .host_tdi(host_tdi), .host_tms(host_tms),
    .host_ntrst(host_ntrst), .host_srst_req(host_srst_req),
    .host_tdo(host_tdo),
    .TCK(TCK), .TDI(TDI), .TMS(TMS), .nTRST(nTRST), .TDO(TDO),
    .nSRST(nSRST), .BUTTON(BUTTON), .LED(LED), .grant(grant)
  );

  always #5 CLK = ~CLK;

`ifdef BB_SRST_STRETCH_EN
  localparam int EXP_OWN_LOW   = 258;
  localparam int EXP_OTHER_LOW = 258;
`else
  localparam int EXP_OWN_LOW   = 3;
  localparam int EXP_OTHER_LOW = 0;
`endif

  typedef struct {
    logic [1:0] g;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n;
  int   n_low;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the next expected grant change and its latency in clock edges.
  task automatic wait_grant(input string tag);
    exp_t       e;
    logic [1:0] prev;
    int         cnt;
    e    = sb.pop_front();
    prev = grant;
    cnt  = 0;
    while (grant === prev && cnt < e.lat + 64) begin
      tick();
      cnt++;
    end
    chk({tag, "_val"}, 32'(grant), 32'(e.g));
    chk({tag, "_lat"}, cnt, e.lat);
  endtask

  task automatic push_exp(input logic [1:0] g, input int lat);
    exp_t e;
    e.g   = g;
    e.lat = lat;
    sb.push_back(e);
  endtask

  initial begin
    nRST = 1'b0; host_tck = '0; host_tdi = '0; host_tms = '0;
    host_ntrst = 2'b11; host_srst_req = '0; TDO = 1'b1; BUTTON = 1'b1;

    // Reset state
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_tck",   32'(TCK),   0);
    chk("rst_tms",   32'(TMS),   1);
    chk("rst_tdi",   32'(TDI),   0);
    chk("rst_ntrst", 32'(nTRST), 1);
    chk("rst_led",   32'(LED),   0);
    chk("rst_tdo",   32'(host_tdo), 2'b11);
    chk("rst_nsrst", 32'(nSRST), 1);
    tick(); nRST = 1'b1;
    repeat (5) tick();
    chk("idle_no_grant", 32'(grant), 0);

    // Single host acquires with one TCK rise
    host_tck[0] = 1'b1;
    push_exp(2'b01, 5);
    wait_grant("grant0");
    chk("own_tck_hi", 32'(TCK), 1);
    host_tck[0] = 1'b0; host_tdi[0] = 1'b1; TDO = 1'b0;
    #1;
    chk("own_tck_lo", 32'(TCK), 0);
    chk("own_tdi",    32'(TDI), 1);
    chk("own_tms",    32'(TMS), 0);
    chk("own_tdo",    32'(host_tdo), 2'b10);
    chk("own_led",    32'(LED), 1);

    // Keep-alive by TMS toggles, then timeout from last toggle
    for (int i = 0; i < 15; i++) begin
      repeat (100) tick();
      chk("keep_grant", 32'(grant), 2'b01);
      host_tms[0] = ~host_tms[0];
    end
    n = 0;
    while (LED === 1'b1 && n < 1200) begin tick(); n++; end
    chk("timeout_lat", n, 1028);
    chk("park_grant", 32'(grant), 0);
    chk("park_tms",   32'(TMS), 1);
    chk("park_tdi",   32'(TDI), 0);
    chk("park_tdo",   32'(host_tdo), 2'b11);

    // Simultaneous activity after reset: host 0 first, host 1 after holdoff
    nRST = 1'b0; host_tck = '0; host_tms = '0; host_tdi = '0; TDO = 1'b1;
    repeat (2) tick();
    nRST = 1'b1;
    repeat (2) tick();
    host_tck = 2'b11;
    push_exp(2'b01, 5);
    push_exp(2'b00, 1024);
    push_exp(2'b10, 5);
    wait_grant("rr_first");
    wait_grant("rr_release");
    wait_grant("rr_second");

    // Button: short bounce ignored, long press releases
    BUTTON = 1'b0;
    repeat (10) tick();
    BUTTON = 1'b1;
    repeat (20) tick();
    chk("bounce_led",   32'(LED), 1);
    chk("bounce_grant", 32'(grant), 2'b10);
    BUTTON = 1'b0;
    n = 0;
    while (LED === 1'b1 && n < 4400) begin
      tick(); n++;
      if (n % 100 == 0) host_tms[1] = ~host_tms[1];
    end
    chk("btn_lat",   n, 4099);
    chk("btn_grant", 32'(grant), 0);
    BUTTON = 1'b1;

    // nSRST behaviour for owner and non-owner requests
    nRST = 1'b0; host_tck = '0; host_tms = '0;
    repeat (2) tick();
    nRST = 1'b1;
    repeat (2) tick();
    host_tck[0] = 1'b1;
    push_exp(2'b01, 5);
    wait_grant("srst_grant");
    host_srst_req[0] = 1'b1;
    n_low = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (nSRST === 1'b0) n_low++;
      if (i == 2) host_srst_req[0] = 1'b0;
    end
    chk("srst_owner_low", n_low, EXP_OWN_LOW);
    host_srst_req[1] = 1'b1;
    n_low = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (nSRST === 1'b0) n_low++;
      if (i == 2) host_srst_req[1] = 1'b0;
    end
    chk("srst_other_low", n_low, EXP_OTHER_LOW);

    // Asynchronous reset while owned with nSRST asserted
    host_srst_req[0] = 1'b1;
    repeat (4) tick();
    chk("pre_rst_nsrst", 32'(nSRST), 0);
    chk("pre_rst_tms",   32'(TMS),   0);
    #2 nRST = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 0);
    chk("arst_tms",   32'(TMS),   1);
    chk("arst_nsrst", 32'(nSRST), 1);
    chk("arst_led",   32'(LED),   0);
    host_srst_req = '0;
    tick();
    nRST = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
